memory_initiator: RTL and testbench

//  Initiator/master side of the 256x16 single-port BRAM interface: turns a CPU-side valid/ready request into the

---
 rtl/mem_initiator_pkg.sv | 17 +
 rtl/mem_burst_counter.sv | 53 +++++
 rtl/memory_initiator.sv | 181 ++++++++++++++++++
 tb/tb_memory_initiator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_initiator_pkg.sv
// Package: mem_initiator_pkg
// Shared definitions for memory_initiator and its burst counter.
//   state_e      : initiator FSM state encodings
//   MEM_ASSERT   : active-low strobe asserted level
//   MEM_DEASSERT : active-low strobe idle level
package mem_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  localparam logic MEM_ASSERT   = 1'b0;
  localparam logic MEM_DEASSERT = 1'b1;

endpackage

// File: rtl/mem_burst_counter.sv
// Module: mem_burst_counter
// Beat bookkeeping for burst requests of memory_initiator.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : request accepted; clear beat count and capture len_i
//   len_i          : beats-1 of the accepted request
//   advance_i      : move to the next beat
//   addr_i         : current memory address
//   next_addr_o    : addr_i + 1, wrapping modulo 1<<AddrWidth
//   last_o         : current beat is the final one
module mem_burst_counter #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned LenWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [LenWidth-1:0]  len_i,
  input  logic                 advance_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic [AddrWidth-1:0] next_addr_o,
  output logic                 last_o
);

  logic [LenWidth-1:0] beat_q, beat_d;
  logic [LenWidth-1:0] len_q,  len_d;

  always_comb begin
    beat_d = beat_q;
    len_d  = len_q;
    if (load_i) begin
      beat_d = '0;
      len_d  = len_i;
    end else if (advance_i) begin
      beat_d = beat_q + LenWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      beat_q <= '0;
      len_q  <= '0;
    end else begin
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end

  // Natural overflow of the fixed-width add gives the 0xFF -> 0x00 wrap.
  assign next_addr_o = addr_i + AddrWidth'(1);
  assign last_o      = (beat_q == len_q);

endmodule

// File: rtl/memory_initiator.sv
// Module: memory_initiator
// Initiator side of a single-port BRAM (active-low Mem_En/Write_EN, memory
// acts on the negedge). Converts a valid/ready request into one or more
// one-cycle memory strobes and returns each beat on a valid/ready response.
// All state and outputs update on posedge Clk.
// Configuration macro: MEM_INIT_BURST_EN -- when defined, Req_Len is honoured
// (beats = Req_Len+1, incrementing/wrapping address); when undefined every
// request is a single beat with Rsp_Last=1.
// Ports:
//   Clk, Reset                 : clock, synchronous active-high reset
//   Req_Valid/Req_Ready        : request handshake (ready only in IDLE)
//   Req_Write/Addr/Data/Len    : request fields
//   Rsp_Valid/Rsp_Ready        : response handshake
//   Rsp_Data/Rsp_Last          : read data (held on write beats), final beat
//   Mem_Address/DIn            : memory address and write data
//   Mem_Write_EN/Mem_En        : active-low memory strobes
//   Mem_DOut                   : memory read data
module memory_initiator
  import mem_initiator_pkg::*;
#(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 16,
  parameter int unsigned LenWidth  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Req_Valid,
  output logic                 Req_Ready,
  input  logic                 Req_Write,
  input  logic [AddrWidth-1:0] Req_Addr,
  input  logic [DataWidth-1:0] Req_Data,
  input  logic [LenWidth-1:0]  Req_Len,
  output logic                 Rsp_Valid,
  input  logic                 Rsp_Ready,
  output logic [DataWidth-1:0] Rsp_Data,
  output logic                 Rsp_Last,
  output logic [AddrWidth-1:0] Mem_Address,
  output logic [DataWidth-1:0] Mem_DIn,
  output logic                 Mem_Write_EN,
  output logic                 Mem_En,
  input  logic [DataWidth-1:0] Mem_DOut
);

  state_e state_q, state_d;

  logic                 write_q,     write_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_last_q,  rsp_last_d;
  logic [DataWidth-1:0] rsp_data_q,  rsp_data_d;
  logic [AddrWidth-1:0] mem_addr_q,  mem_addr_d;
  logic [DataWidth-1:0] mem_din_q,   mem_din_d;
  logic                 mem_we_n_q,  mem_we_n_d;
  logic                 mem_en_n_q,  mem_en_n_d;

  logic                 burst_load;
  logic                 burst_advance;
  logic                 beat_last;
  logic [AddrWidth-1:0] next_addr;

`ifdef MEM_INIT_BURST_EN
  mem_burst_counter #(
    .AddrWidth (AddrWidth),
    .LenWidth  (LenWidth)
  ) u_burst_counter (
    .clk_i       (Clk),
    .reset_i     (Reset),
    .load_i      (burst_load),
    .len_i       (Req_Len),
    .advance_i   (burst_advance),
    .addr_i      (mem_addr_q),
    .next_addr_o (next_addr),
    .last_o      (beat_last)
  );
`else
  // Single-beat build: every beat is the last, so next_addr is never taken.
  logic unused_burst;
  assign unused_burst = ^{Req_Len, burst_load, burst_advance};
  assign beat_last    = 1'b1;
  assign next_addr    = mem_addr_q;
`endif

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_last_d    = rsp_last_q;
    rsp_data_d    = rsp_data_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_we_n_d    = mem_we_n_q;
    mem_en_n_d    = mem_en_n_q;
    burst_load    = 1'b0;
    burst_advance = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Req_Valid) begin
          write_d     = Req_Write;
          mem_addr_d  = Req_Addr;
          mem_din_d   = Req_Data;
          mem_we_n_d  = Req_Write ? MEM_ASSERT : MEM_DEASSERT;
          mem_en_n_d  = MEM_ASSERT;
          req_ready_d = 1'b0;
          burst_load  = 1'b1;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // The memory has acted on the mid-cycle negedge; drop the strobes.
        mem_en_n_d  = MEM_DEASSERT;
        mem_we_n_d  = MEM_DEASSERT;
        if (!write_q) begin
          rsp_data_d = Mem_DOut;
        end
        rsp_valid_d = 1'b1;
        rsp_last_d  = beat_last;
        state_d     = ST_RESPOND;
      end

      ST_RESPOND: begin
        if (Rsp_Ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (rsp_last_q) begin
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            mem_addr_d    = next_addr;
            mem_en_n_d    = MEM_ASSERT;
            mem_we_n_d    = write_q ? MEM_ASSERT : MEM_DEASSERT;
            burst_advance = 1'b1;
            state_d       = ST_ACCESS;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_n_q  <= MEM_DEASSERT;
      mem_en_n_q  <= MEM_DEASSERT;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_n_q  <= mem_we_n_d;
      mem_en_n_q  <= mem_en_n_d;
    end
  end

  assign Req_Ready    = req_ready_q;
  assign Rsp_Valid    = rsp_valid_q;
  assign Rsp_Last     = rsp_last_q;
  assign Rsp_Data     = rsp_data_q;
  assign Mem_Address  = mem_addr_q;
  assign Mem_DIn      = mem_din_q;
  assign Mem_Write_EN = mem_we_n_q;
  assign Mem_En       = mem_en_n_q;

endmodule

// File: tb/tb_memory_initiator.sv
// Testbench for memory_initiator paired with a 256x16 negedge BRAM model.
module tb_memory_initiator;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic        Req_Write = 1'b0;
  logic [7:0]  Req_Addr = '0;
  logic [15:0] Req_Data = '0;
  logic [7:0]  Req_Len = '0;
  logic        Rsp_Valid;
  logic        Rsp_Ready = 1'b1;
  logic [15:0] Rsp_Data;
  logic        Rsp_Last;
  logic [7:0]  Mem_Address;
  logic [15:0] Mem_DIn;
  logic        Mem_Write_EN;
  logic        Mem_En;
  logic [15:0] Mem_DOut = '0;

  int n_cmp = 0;
  int n_err = 0;
  int en_low_cnt = 0;

  logic [15:0] bram [256];

  memory_initiator #(
    .AddrWidth (8),
    .DataWidth (16),
    .LenWidth  (8)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req_Valid    (Req_Valid),
    .Req_Ready    (Req_Ready),
    .Req_Write    (Req_Write),
    .Req_Addr     (Req_Addr),
    .Req_Data     (Req_Data),
    .Req_Len      (Req_Len),
    .Rsp_Valid    (Rsp_Valid),
    .Rsp_Ready    (Rsp_Ready),
    .Rsp_Data     (Rsp_Data),
    .Rsp_Last     (Rsp_Last),
    .Mem_Address  (Mem_Address),
    .Mem_DIn      (Mem_DIn),
    .Mem_Write_EN (Mem_Write_EN),
    .Mem_En       (Mem_En),
    .Mem_DOut     (Mem_DOut)
  );

  always #5 Clk = ~Clk;

  // BRAM model: acts on the negedge while Mem_En is low.
  always @(negedge Clk) begin
    if (Mem_En === 1'b0) begin
      if (Mem_Write_EN === 1'b0) bram[Mem_Address] <= Mem_DIn;
      else                       Mem_DOut <= bram[Mem_Address];
    end
  end

  // Counts cycles in which the memory was strobed.
  always @(posedge Clk) begin
    if (Mem_En === 1'b0) en_low_cnt <= en_low_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (Req_Ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk({nm, "_ready_timeout"}, 32'(Req_Ready), 32'd1);
  endtask

  // Issue a request with Rsp_Ready held high and check every beat.
  task automatic do_req(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic [7:0] l, input int beats,
                        input logic [15:0] exp, input string nm);
    int snap;
    int cyc;
    Rsp_Ready = 1'b1;
    wait_ready(nm);
    snap      = en_low_cnt;
    Req_Valid = 1'b1;
    Req_Write = w;
    Req_Addr  = a;
    Req_Data  = d;
    Req_Len   = l;
    tick();
    Req_Valid = 1'b0;
    chk({nm, "_acc_ready"}, 32'(Req_Ready), 32'd0);
    chk({nm, "_acc_en"}, 32'(Mem_En), 32'd0);
    chk({nm, "_acc_addr"}, 32'(Mem_Address), 32'(a));
    chk({nm, "_acc_we"}, 32'(Mem_Write_EN), 32'(!w));
    for (int b = 0; b < beats; b++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (Rsp_Valid !== 1'b1 && cyc < 8);
      chk($sformatf("%s_b%0d_lat", nm, b), 32'(cyc), (b == 0) ? 32'd1 : 32'd2);
      chk($sformatf("%s_b%0d_last", nm, b), 32'(Rsp_Last), 32'(b == beats - 1));
      chk($sformatf("%s_b%0d_data", nm, b), 32'(Rsp_Data), 32'(exp));
    end
    tick();
    chk({nm, "_done_valid"}, 32'(Rsp_Valid), 32'd0);
    chk({nm, "_done_ready"}, 32'(Req_Ready), 32'd1);
    chk({nm, "_strobes"}, 32'(en_low_cnt - snap), 32'(beats));
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int snap;

    for (int i = 0; i < 256; i++) bram[i] = '0;

    // exp is the Rsp_Data value seen on the response: read data for reads,
    // the last read value (held) for writes.
    vecs[0] = '{1'b1, 8'h12, 16'hBEEF, 16'h0000, "wr12"};
    vecs[1] = '{1'b0, 8'h12, 16'h0000, 16'hBEEF, "rd12"};
    vecs[2] = '{1'b1, 8'h00, 16'h1234, 16'hBEEF, "wr00"};
    vecs[3] = '{1'b1, 8'hFF, 16'hA5A5, 16'hBEEF, "wrFF"};
    vecs[4] = '{1'b1, 8'hFE, 16'h5A5A, 16'hBEEF, "wrFE"};
    vecs[5] = '{1'b1, 8'h01, 16'hC3C3, 16'hBEEF, "wr01"};
    vecs[6] = '{1'b1, 8'h02, 16'h7777, 16'hBEEF, "wr02"};
    vecs[7] = '{1'b0, 8'hFF, 16'h0000, 16'hA5A5, "rdFF"};
    vecs[8] = '{1'b0, 8'h00, 16'h0000, 16'h1234, "rd00"};
    vecs[9] = '{1'b0, 8'h02, 16'h0000, 16'h7777, "rd02"};

    // Reset
    Reset = 1'b1;
    repeat (2) tick();
    chk("rst_ready", 32'(Req_Ready), 32'd1);
    chk("rst_en", 32'(Mem_En), 32'd1);
    chk("rst_we", 32'(Mem_Write_EN), 32'd1);
    chk("rst_valid", 32'(Rsp_Valid), 32'd0);
    chk("rst_data", 32'(Rsp_Data), 32'd0);
    chk("rst_last", 32'(Rsp_Last), 32'd0);
    chk("rst_addr", 32'(Mem_Address), 32'd0);
    Reset = 1'b0;
    tick();

    // Single-beat table
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].w, vecs[i].addr, vecs[i].data, 8'd0, 1, vecs[i].exp, vecs[i].name);
    end

    // Backpressure: response stalled for 5 cycles
    Rsp_Ready = 1'b0;
    wait_ready("bp");
    snap      = en_low_cnt;
    Req_Valid = 1'b1;
    Req_Write = 1'b0;
    Req_Addr  = 8'h12;
    Req_Len   = 8'd0;
    tick();
    Req_Valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_c%0d_valid", c), 32'(Rsp_Valid), 32'd1);
      chk($sformatf("bp_c%0d_data", c), 32'(Rsp_Data), 32'hBEEF);
      chk($sformatf("bp_c%0d_en", c), 32'(Mem_En), 32'd1);
      tick();
    end
    chk("bp_strobes", 32'(en_low_cnt - snap), 32'd1);
    Rsp_Ready = 1'b1;
    tick();
    chk("bp_done_valid", 32'(Rsp_Valid), 32'd0);
    chk("bp_done_ready", 32'(Req_Ready), 32'd1);

`ifdef MEM_INIT_BURST_EN
    // Burst fill with wrap: 0xFE,0xFF,0x00,0x01 cleared, 0x02 untouched
    do_req(1'b1, 8'hFE, 16'h0000, 8'd3, 4, 16'hBEEF, "bfill");
    chk("bfill_FE", 32'(bram[8'hFE]), 32'd0);
    chk("bfill_FF", 32'(bram[8'hFF]), 32'd0);
    chk("bfill_00", 32'(bram[8'h00]), 32'd0);
    chk("bfill_01", 32'(bram[8'h01]), 32'd0);
    chk("bfill_02", 32'(bram[8'h02]), 32'h7777);
    do_req(1'b0, 8'hFE, 16'h0000, 8'd3, 4, 16'h0000, "brd");

    // Reset during the third beat of a Len=7 read
    wait_ready("mrst");
    Req_Valid = 1'b1;
    Req_Write = 1'b0;
    Req_Addr  = 8'h10;
    Req_Len   = 8'd7;
    tick();
    Req_Valid = 1'b0;
    repeat (4) tick();
    chk("mrst_in_access", 32'(Mem_En), 32'd0);
    chk("mrst_addr", 32'(Mem_Address), 32'h12);
`else
    // Len ignored: single beat
    do_req(1'b0, 8'h12, 16'h0000, 8'd5, 1, 16'hBEEF, "nolen");

    // Reset while a response is pending
    Rsp_Ready = 1'b0;
    wait_ready("mrst");
    Req_Valid = 1'b1;
    Req_Write = 1'b0;
    Req_Addr  = 8'h00;
    Req_Len   = 8'd0;
    tick();
    Req_Valid = 1'b0;
    tick();
    chk("mrst_pending", 32'(Rsp_Valid), 32'd1);
`endif
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Rsp_Ready = 1'b1;
    snap = en_low_cnt;
    repeat (4) begin
      tick();
      chk("mrst_en_high", 32'(Mem_En), 32'd1);
    end
    chk("mrst_strobes", 32'(en_low_cnt - snap), 32'd0);
    chk("mrst_valid", 32'(Rsp_Valid), 32'd0);
    chk("mrst_ready", 32'(Req_Ready), 32'd1);
    chk("mrst_data", 32'(Rsp_Data), 32'd0);

    do_req(1'b0, 8'h12, 16'h0000, 8'd0, 1, 16'hBEEF, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
